// File: rtl/mc_control_fsm.sv
// ============================================================================
// Module   : mc_control_fsm
// Brief    : Multi-cycle MIPS main control FSM with memory-ready handshake,
//            opcode/funct validation, sticky error flag and retire counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_control_fsm #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    input  logic               error_clear,
    output logic               pc_write,
    output logic               branch,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic [3:0]         state,
    output logic               error_flag,
    output logic [COUNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP_EX  = 4'd11,
        S_ERROR    = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t             state_q, state_d;
    logic               error_flag_q;
    logic [COUNT_W-1:0] retired_q;
    logic               retire;
    logic               funct_ok;

    logic pc_write_raw, branch_raw, mem_write_raw, ir_write_raw, reg_write_raw;

    always_comb begin
        funct_ok = 1'b0;
        case (funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write_raw  = 1'b0;
        branch_raw    = 1'b0;
        iord          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write_raw = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        case (state_q)
            S_FETCH: begin
                alu_src_b    = 2'b01;
                pc_write_raw = mem_ready;
                ir_write_raw = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_ok ? S_RTYPE_EX : S_ERROR;
                    OP_BEQ:       state_d = S_BEQ_EX;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP_EX;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // IR is stable, so the opcode is still valid for the lw/sw split
                case (opcode)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    default: state_d = S_ERROR;
                endcase
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_MEMWR: begin
                iord          = 1'b1;
                mem_write_raw = mem_ready;
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_BEQ_EX: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                branch_raw = 1'b1;
                state_d    = S_FETCH;
                retire     = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
                retire        = 1'b1;
            end
            S_JUMP_EX: begin
                pc_src       = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = S_FETCH;
                retire       = 1'b1;
            end
            S_ERROR: begin
                if (error_clear) state_d = S_FETCH;
            end
            default: state_d = S_ERROR;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FETCH;
            error_flag_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            error_flag_q <= (state_d == S_ERROR);
            if (retire) retired_q <= retired_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Strobes are forced low combinationally while reset is held
    assign pc_write   = pc_write_raw  & reset_n;
    assign branch     = branch_raw    & reset_n;
    assign mem_write  = mem_write_raw & reset_n;
    assign ir_write   = ir_write_raw  & reset_n;
    assign reg_write  = reg_write_raw & reset_n;
    assign state      = state_q;
    assign error_flag = error_flag_q;
    assign retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// Module   : tb_mc_control_fsm
// Brief    : Directed bench for mc_control_fsm with a path-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [5:0]    opcode, funct;
    logic          mem_ready, error_clear;
    logic          pc_write, branch, iord, mem_write, ir_write;
    logic          reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]    alu_src_b, alu_op, pc_src;
    logic [3:0]    state;
    logic          error_flag;
    logic [CW-1:0] retired;
    logic [14:0]   dut_ctrl;

    int n_chk  = 0;
    int n_fail = 0;

    mc_control_fsm #(.COUNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .error_clear(error_clear),
        .pc_write(pc_write), .branch(branch), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .state(state),
        .error_flag(error_flag), .retired(retired)
    );

    always #5 clock = ~clock;

    assign dut_ctrl = {pc_write, branch, iord, mem_write, ir_write, reg_dst,
                       mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each instruction class is a fixed path of state codes
    // classes: 0 lw, 1 sw, 2 R, 3 beq, 4 addi, 5 j, 6 illegal
    int tbl [0:6][0:4] = '{'{0,1,2,3,4}, '{0,1,2,5,0}, '{0,1,6,7,0}, '{0,1,8,0,0},
                           '{0,1,9,10,0}, '{0,1,11,0,0}, '{0,1,15,0,0}};
    int plen [0:6] = '{5, 4, 4, 3, 4, 3, 3};
    int m_pos = 0;
    int m_cls = 0;
    int m_ret = 0;
    bit m_err = 1'b0;

    function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b100011: return 0;
            6'b101011: return 1;
            6'b000000: return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                               fn == 6'h25 || fn == 6'h2A) ? 2 : 6;
            6'b000100: return 3;
            6'b001000: return 4;
            6'b000010: return 5;
            default:   return 6;
        endcase
    endfunction

    function automatic logic [14:0] exp_ctrl(input int st, input logic mr, input logic rn);
        logic [14:0] w;
        case (st)
            0:  w = 15'b000000000_01_00_00 | (mr ? 15'b100010000_00_00_00 : 15'b0);
            1:  w = 15'b000000000_11_00_00;
            2:  w = 15'b000000001_10_00_00;
            3:  w = 15'b001000000_00_00_00;
            4:  w = 15'b000000110_00_00_00;
            5:  w = 15'b001000000_00_00_00 | (mr ? 15'b000100000_00_00_00 : 15'b0);
            6:  w = 15'b000000001_00_10_00;
            7:  w = 15'b000001010_00_00_00;
            8:  w = 15'b010000001_00_01_01;
            9:  w = 15'b000000001_10_00_00;
            10: w = 15'b000000010_00_00_00;
            11: w = 15'b100000000_00_00_10;
            default: w = 15'b0;
        endcase
        if (!rn) w &= ~15'b110110010_00_00_00;
        return w;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        int cur;
        if (!reset_n) begin
            m_pos <= 0; m_cls <= 0; m_ret <= 0; m_err <= 1'b0;
        end else begin
            cur = tbl[m_cls][m_pos];
            if (cur == 15) begin
                if (error_clear) begin
                    m_pos <= 0;
                    m_err <= 1'b0;
                end
            end else if ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) begin
                m_pos <= m_pos;
            end else if (m_pos == 1) begin
                m_cls <= cls_of(opcode, funct);
                m_pos <= 2;
                if (cls_of(opcode, funct) == 6) m_err <= 1'b1;
            end else if (m_pos == plen[m_cls] - 1) begin
                m_pos <= 0;
                m_ret <= (m_ret + 1) % (1 << CW);
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clock) begin
        int est;
        est = tbl[m_cls][m_pos];
        chk("model_state", 32'(state), 32'(est));
        chk("model_ctrl", 32'(dut_ctrl), 32'(exp_ctrl(est, mem_ready, reset_n)));
        if (reset_n) begin
            chk("model_flag", 32'(error_flag), 32'(m_err));
            chk("model_retired", 32'(retired), 32'(m_ret));
        end
    end

    // Directed stimulus; samples captured at the negedge of each cycle
    logic [14:0] s_ctrl;
    logic        s_flag;
    int          ir_cnt, mw_cnt;
    bit          rw_seen;

    task automatic cyc(input logic [3:0] exp_state);
        @(negedge clock);
        chk("seq_state", 32'(state), 32'(exp_state));
        s_ctrl = dut_ctrl;
        s_flag = error_flag;
        ir_cnt += int'(ir_write);
        mw_cnt += int'(mem_write);
        if (reg_write) rw_seen = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; mem_ready = 1'b1; error_clear = 1'b0;
        opcode = 6'b0; funct = 6'h20;
        @(negedge clock);
        chk("rst_pc_write", 32'(pc_write), 32'd0);
        chk("rst_ir_write", 32'(ir_write), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_flag", 32'(error_flag), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // R-type add
        cyc(0); chk("r_ir_write", 32'(s_ctrl[10]), 32'd1);
        cyc(1); cyc(6);
        cyc(7);
        chk("r_reg_write", 32'(s_ctrl[7]), 32'd1);
        chk("r_reg_dst", 32'(s_ctrl[9]), 32'd1);
        chk("r_retired", 32'(retired), 32'd1);

        // lw with stalled fetch and read
        opcode = 6'b100011; mem_ready = 1'b0; ir_cnt = 0;
        cyc(0); cyc(0);
        mem_ready = 1'b1;
        cyc(0); cyc(1); cyc(2);
        mem_ready = 1'b0; cyc(3);
        mem_ready = 1'b1; cyc(3);
        cyc(4); chk("lw_mem_to_reg", 32'(s_ctrl[8]), 32'd1);
        chk("lw_ir_pulses", 32'(ir_cnt), 32'd1);
        chk("lw_retired", 32'(retired), 32'd2);

        // sw
        opcode = 6'b101011; mw_cnt = 0; rw_seen = 1'b0;
        cyc(0); cyc(1); cyc(2);
        cyc(5);
        chk("sw_mem_write", 32'(s_ctrl[11]), 32'd1);
        chk("sw_iord", 32'(s_ctrl[12]), 32'd1);
        chk("sw_mw_pulses", 32'(mw_cnt), 32'd1);
        chk("sw_no_reg_write", 32'(rw_seen), 32'd0);
        chk("sw_retired", 32'(retired), 32'd3);

        // illegal opcode, flag held for 10 cycles
        opcode = 6'b111111;
        cyc(0); cyc(1);
        for (int i = 0; i < 10; i++) begin
            cyc(15);
            chk("err_flag", 32'(s_flag), 32'd1);
            chk("err_strobes", 32'(s_ctrl & 15'b110110010_00_00_00), 32'd0);
        end
        error_clear = 1'b1; cyc(15);
        error_clear = 1'b0;
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_flag", 32'(error_flag), 32'd0);
        chk("clr_retired", 32'(retired), 32'd3);

        // R-type with bad funct
        opcode = 6'b000000; funct = 6'b111111;
        cyc(0); cyc(1); cyc(15);
        chk("badfn_flag", 32'(s_flag), 32'd1);
        error_clear = 1'b1; cyc(15);
        error_clear = 1'b0; funct = 6'h20;

        // beq with error_clear held (no effect outside ERROR)
        opcode = 6'b000100; error_clear = 1'b1;
        cyc(0); cyc(1);
        cyc(8);
        chk("beq_branch", 32'(s_ctrl[13]), 32'd1);
        chk("beq_alu_op", 32'(s_ctrl[3:2]), 32'd1);
        chk("beq_retired", 32'(retired), 32'd4);
        error_clear = 1'b0;

        // j
        opcode = 6'b000010;
        cyc(0); cyc(1);
        cyc(11);
        chk("j_pc_write", 32'(s_ctrl[14]), 32'd1);
        chk("j_pc_src", 32'(s_ctrl[1:0]), 32'd2);

        // addi
        opcode = 6'b001000;
        cyc(0); cyc(1); cyc(9);
        cyc(10);
        chk("addi_reg_write", 32'(s_ctrl[7]), 32'd1);
        chk("addi_retired", 32'(retired), 32'd6);

        // async reset while stalled in MEMWR
        opcode = 6'b101011;
        cyc(0); cyc(1);
        mem_ready = 1'b0;
        cyc(2);
        @(negedge clock);
        chk("memwr_state", 32'(state), 32'd5);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_mem_write", 32'(mem_write), 32'd0);
        chk("arst_retired", 32'(retired), 32'd0);
        chk("arst_flag", 32'(error_flag), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1; mem_ready = 1'b1;

        // counter wrap with 16 jumps
        opcode = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            cyc(0); cyc(1); cyc(11);
            if (i == 14) chk("wrap_pre", 32'(retired), 32'd15);
        end
        chk("wrap_zero", 32'(retired), 32'd0);

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Main control state machine for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback, and drives every datapath control strobe. It qualifies memory accesses with a ready handshake and validates the opcode and R-type funct. It raises a sticky error_flag on an unsupported encoding, which the top level exports.

Parameters:
COUNT_W, 16, width of retired-instruction counter

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
opcode  input  6  instruction[31:26] from instruction register
funct  input  6  instruction[5:0] from instruction register
mem_ready  input  1  memory completes current access this cycle
error_clear  input  1  leave ERROR state, clear error_flag
pc_write  output  1  unconditional PC load
branch  output  1  PC load if ALU zero
iord  output  1  0=PC address, 1=ALUOut address
mem_write  output  1  memory write strobe
ir_write  output  1  instruction register load
reg_dst  output  1  1=rd, 0=rt
mem_to_reg  output  1  1=MDR, 0=ALUOut
reg_write  output  1  register file write
alu_src_a  output  1  0=PC, 1=regA
alu_src_b  output  2  00=regB, 01=4, 10=signext, 11=signext<<2
alu_op  output  2  00=add, 01=sub, 10=funct
pc_src  output  2  00=ALU, 01=ALUOut, 10=jump target
state  output  4  current state encoding
error_flag  output  1  sticky illegal-instruction flag
retired  output  COUNT_W  retired-instruction count

Behaviour:
- Reset: async, active-low. Sets state=FETCH(0), error_flag=0, retired=0. While reset_n=0, all strobes (pc_write, ir_write, mem_write, reg_write, branch) are 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, RTYPE_WB=7, BEQ_EX=8, ADDI_EX=9, ADDI_WB=10, JUMP_EX=11, ERROR=15. Codes 12-14 are unused and go to ERROR next cycle.
- Outputs are Moore decodes of state. Exception: pc_write and ir_write in FETCH, and mem_write in MEMWR, are additionally gated by mem_ready. Any output not listed for a state is 0.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. If mem_ready=1: ir_write=1, pc_write=1, next=DECODE. Otherwise hold in FETCH with no strobes.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw): MEMADR
  - 000000: RTYPE_EX if funct is in {100000, 100010, 100100, 100101, 101010}; otherwise ERROR
  - 000100: BEQ_EX
  - 001000: ADDI_EX
  - 000010: JUMP_EX
  - any other opcode: ERROR
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEMRD for lw, MEMWR for sw. Opcode is re-examined here; the IR is stable.
- MEMRD: iord=1. Wait for mem_ready, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next FETCH; retire.
- MEMWR: iord=1, mem_write=mem_ready. On mem_ready go to FETCH and retire; otherwise hold.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Next RTYPE_WB.
- RTYPE_WB: reg_dst=1, mem_to_reg=0, reg_write=1. Next FETCH; retire.
- BEQ_EX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Next FETCH; retire.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1. Next FETCH; retire.
- JUMP_EX: pc_src=10, pc_write=1. Next FETCH; retire.
- ERROR: all strobes 0. error_flag is set on entry and held. The state holds until error_clear=1. On the next edge after that: error_flag=0, state=FETCH. error_clear has no effect in any other state.
- Retire: retired increments by 1 on the clock edge that leaves a final state. It wraps from 2^COUNT_W-1 to 0. Instructions that end in ERROR do not retire.
- Latencies with mem_ready held high:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type and addi: 4 cycles
  - beq and j: 3 cycles
  - Each extra cycle with mem_ready low adds one cycle.
- reset_n asserted mid-instruction: immediate return to FETCH. No partial strobe survives; the counter and flag are cleared.

Test Plan:
- Reset, then opcode=000000, funct=100000, mem_ready=1 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 in state 7; retired=1.
- lw (100011), with mem_ready low for 2 cycles in FETCH and 1 cycle in MEMRD -> FETCH held 3 cycles; ir_write pulses once; sequence 0,1,2,3,4,0 totalling 8 cycles; mem_to_reg=1 in state 4.
- sw (101011) with mem_ready=1 -> mem_write=1 for exactly one cycle in state 5 with iord=1; retired increments; reg_write is never 1.
- opcode=111111 -> state 15 after DECODE; error_flag=1 and held for 10 cycles with all strobes 0. Then pulse error_clear -> state 0, error_flag=0, retired unchanged.
- opcode=000000, funct=111111 -> ERROR with error_flag=1. Also check beq -> branch=1, alu_op=01 in state 8; j -> pc_write=1, pc_src=10 in state 11.
- Drive reset_n low during MEMWR with mem_ready=0 -> state=0, mem_write=0 immediately (async). Then preload 65535 retirements (or use COUNT_W=4 and 16 retirements) -> retired wraps to 0.
